// File: rtl/radix_mult.sv
// radix_mult: iterative shift-and-add multiplier retiring RADIX_BITS multiplier
// bits per RUN cycle, with signed (two's complement) or unsigned operands.
// Signed operands are reduced to magnitudes up front and the sign is
// restored in a single FIX cycle, so the datapath is purely unsigned.
// Optional feature: define RADIX_MULT_EARLY_TERM_EN to leave RUN as soon as
// the remaining multiplier magnitude becomes zero.
module radix_mult #(
  parameter int WIDTH      = 16,
  parameter int RADIX_BITS = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int N  = WIDTH / RADIX_BITS;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand_sh;
  logic [WIDTH-1:0]     mplier_rem;
  logic                 res_sign;
  logic [CW-1:0]        run_cnt;

  logic [WIDTH-1:0]     mcand_mag_in;
  logic [WIDTH-1:0]     mplier_mag_in;
  logic [2*WIDTH-1:0]   digit_ext;
  logic [2*WIDTH-1:0]   partial;
  logic [WIDTH-1:0]     mplier_next;
  logic                 last_run;

  assign busy = (state == RUN) || (state == FIX);

  // Operand magnitudes (the most negative value maps to 2^(WIDTH-1), which
  // still fits unsigned in WIDTH bits) and the per-cycle partial product.
  always_comb begin
    mcand_mag_in  = (signed_mode && mcand[WIDTH-1])  ? (~mcand  + ONE_W) : mcand;
    mplier_mag_in = (signed_mode && mplier[WIDTH-1]) ? (~mplier + ONE_W) : mplier;
    digit_ext     = {{(2*WIDTH-RADIX_BITS){1'b0}}, mplier_rem[RADIX_BITS-1:0]};
    partial       = mcand_sh * digit_ext;
    mplier_next   = mplier_rem >> RADIX_BITS;
`ifdef RADIX_MULT_EARLY_TERM_EN
    last_run      = (run_cnt == CW'(N - 1)) || (mplier_next == '0);
`else
    last_run      = (run_cnt == CW'(N - 1));
`endif
  end

  // Control FSM and datapath: accept when idle/done, accumulate in RUN,
  // apply the sign in FIX, then hold the result in DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      acc        <= '0;
      mcand_sh   <= '0;
      mplier_rem <= '0;
      res_sign   <= 1'b0;
      run_cnt    <= '0;
      product    <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand_sh   <= {{WIDTH{1'b0}}, mcand_mag_in};
            mplier_rem <= mplier_mag_in;
            res_sign   <= signed_mode & (mcand[WIDTH-1] ^ mplier[WIDTH-1]);
            acc        <= '0;
            run_cnt    <= '0;
            done       <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          acc        <= acc + partial;
          mcand_sh   <= mcand_sh << RADIX_BITS;
          mplier_rem <= mplier_next;
          run_cnt    <= run_cnt + CW'(1);
          if (last_run) begin
            state <= FIX;
          end
        end
        FIX: begin
          product <= res_sign ? (~acc + ONE_2W) : acc;
          done    <= 1'b1;
          state   <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_radix_mult.sv
// tb_radix_mult: self-checking bench for radix_mult (WIDTH=16, RADIX_BITS=2).
// A transaction-level model predicts busy/done/product from the arithmetic
// product and the expected latency; directed cases pin the model with
// hand-computed literals. Honours RADIX_MULT_EARLY_TERM_EN when defined.
module tb_radix_mult;

  localparam int WIDTH = 16;
  localparam int RB    = 2;
  localparam int N     = WIDTH / RB;
`ifdef RADIX_MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic              clock       = 1'b0;
  logic              reset_n     = 1'b1;
  logic              start       = 1'b0;
  logic              signed_mode = 1'b0;
  logic [WIDTH-1:0]  mcand       = '0;
  logic [WIDTH-1:0]  mplier      = '0;
  logic [2*WIDTH-1:0] product;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  radix_mult #(.WIDTH(WIDTH), .RADIX_BITS(RB)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .signed_mode (signed_mode),
    .mcand       (mcand),
    .mplier      (mplier),
    .product     (product),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  // Exact product of the interpreted operands, truncated to 2*WIDTH bits.
  function automatic logic [2*WIDTH-1:0] refProduct(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic sm);
    longint x, y, p;
    x = sm ? longint'($signed(a)) : longint'(a);
    y = sm ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[2*WIDTH-1:0];
  endfunction

  // Edges from acceptance until done: N RUN edges plus FIX, or with early
  // termination one RUN edge per multiplier digit up to the top nonzero one.
  function automatic int refLatency(input logic [WIDTH-1:0] b, input logic sm);
    int v, runs;
    if (!EARLY) return N + 1;
    v = sm ? int'($signed(b)) : int'(b);
    if (v < 0) v = -v;
    runs = 1;
    for (int i = 0; i < N; i++) begin
      if ((v >> (RB * i)) != 0) runs = i + 1;
    end
    return runs + 1;
  endfunction

  task automatic recordCheck(input bit ok, input string name,
                             input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, req);
    end
  endtask

  // Transaction model state
  logic               m_busy       = 1'b0;
  logic               m_done       = 1'b0;
  logic [2*WIDTH-1:0] m_prod       = '0;
  logic [2*WIDTH-1:0] m_pending    = '0;
  bit                 m_prod_valid = 1'b1;
  int                 m_left       = 0;

  // Model: an accepted start schedules the arithmetic result refLatency edges later.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy       <= 1'b0;
      m_done       <= 1'b0;
      m_prod       <= '0;
      m_prod_valid <= 1'b1;
      m_left       <= 0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy       <= 1'b0;
        m_done       <= 1'b1;
        m_prod       <= m_pending;
        m_prod_valid <= 1'b1;
      end
      m_left <= m_left - 1;
    end else if (start) begin
      m_busy       <= 1'b1;
      m_done       <= 1'b0;
      m_prod_valid <= 1'b0;
      m_pending    <= refProduct(mcand, mplier, signed_mode);
      m_left       <= refLatency(mplier, signed_mode);
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clock) begin
    recordCheck(busy === m_busy, "model_busy", 32'(busy), 32'(m_busy));
    recordCheck(done === m_done, "model_done", 32'(done), 32'(m_done));
    if (m_prod_valid)
      recordCheck(product === m_prod, "model_product", product, m_prod);
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] mc, input logic [WIDTH-1:0] mp,
                               input logic sm);
    @(negedge clock);
    start       = 1'b1;
    mcand       = mc;
    mplier      = mp;
    signed_mode = sm;
    @(posedge clock);
  endtask

  // Follows one operation from edge 0; optionally pulses start with junk
  // operands at edge 'inject' while busy; checks latency and final product.
  task automatic checkOutput(input logic [2*WIDTH-1:0] exp_prod, input int exp_lat,
                             input string name, input int inject);
    int lat;
    lat = -1;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clock);
      if (i == 0) begin
        recordCheck(busy === 1'b1 && done === 1'b0, {name, "_accept"},
                    {30'd0, busy, done}, 32'h2);
      end else if (done === 1'b1) begin
        lat = i;
        break;
      end else begin
        recordCheck(busy === 1'b1, {name, "_busy"}, 32'(busy), 32'h1);
      end
      start       = (i + 1 == inject);
      mcand       = 16'($urandom);
      mplier      = 16'($urandom);
      signed_mode = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    recordCheck(lat == exp_lat, {name, "_latency"}, 32'(lat), 32'(exp_lat));
    recordCheck(product === exp_prod, {name, "_product"}, product, exp_prod);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #2;
    recordCheck(busy === 1'b0, "reset_busy", 32'(busy), 32'h0);
    recordCheck(done === 1'b0, "reset_done", 32'(done), 32'h0);
    recordCheck(product === 32'h0, "reset_product", product, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    applyStimulus(16'h0002, 16'h0003, 1'b0);
    checkOutput(32'h00000006, EARLY ? 2 : 9, "u_2x3", 0);
    applyStimulus(16'hFFFF, 16'h0003, 1'b1);
    checkOutput(32'hFFFFFFFD, EARLY ? 2 : 9, "s_m1x3", 0);
    applyStimulus(16'hFFFF, 16'h0003, 1'b0);
    checkOutput(32'h0002FFFD, EARLY ? 2 : 9, "u_ffffx3", 0);
    applyStimulus(16'h8000, 16'h8000, 1'b1);
    checkOutput(32'h40000000, 9, "s_min_sq", 0);
    applyStimulus(16'hFFEC, 16'h0005, 1'b1);
    checkOutput(32'hFFFFFF9C, EARLY ? 3 : 9, "s_m20x5", 0);
    applyStimulus(16'h1234, 16'h0056, 1'b0);
    checkOutput(32'h00061D78, EARLY ? 5 : 9, "busy_start", 4);

    // Reset pulled low just after edge 5 of an operation.
    applyStimulus(16'h00AB, 16'hCDEF, 1'b0);
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    recordCheck(busy === 1'b0, "midreset_busy", 32'(busy), 32'h0);
    recordCheck(done === 1'b0, "midreset_done", 32'(done), 32'h0);
    recordCheck(product === 32'h0, "midreset_product", product, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      recordCheck(done === 1'b0, "post_reset_done", 32'(done), 32'h0);
    end
    applyStimulus(16'h0007, 16'h0009, 1'b0);
    checkOutput(32'h0000003F, EARLY ? 3 : 9, "after_reset", 0);

    applyStimulus(16'hBEEF, 16'h0000, 1'b0);
    checkOutput(32'h00000000, EARLY ? 2 : 9, "zero_mplier", 0);
    applyStimulus(16'h1234, 16'h0100, 1'b0);
    checkOutput(32'h00123400, EARLY ? 6 : 9, "mplier_0100", 0);

    for (int k = 0; k < 30; k++) begin
      logic [WIDTH-1:0] mc, mp;
      logic sm;
      int lat, inj;
      mc  = 16'($urandom);
      mp  = 16'($urandom) >> $urandom_range(0, 15);
      sm  = 1'($urandom_range(0, 1));
      lat = refLatency(mp, sm);
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat - 1)) : 0;
      applyStimulus(mc, mp, sm);
      checkOutput(refProduct(mc, mp, sm), lat, "random", inj);
    end

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
